// File: rtl/pll_scan_responder.sv
// PLL reconfiguration responder: loads a shadow scan chain serially from the config ROM and
// shifts it into the ALTPLL scan port, then pulses configupdate and waits for scandone.
module pll_scan_responder #(
    parameter int SCAN_LEN = 144,
    parameter int ADDR_W   = 8,
    parameter int ROM_LAT  = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_from_rom,
    input  logic              reconfig,
    input  logic              reset_rom_address,
    output logic [ADDR_W-1:0] rom_address,
    input  logic              rom_data,
    output logic              busy,
    output logic              scandata,
    output logic              scanclkena,
    output logic              configupdate,
    input  logic              pll_scandone,
    output logic              timeout_err
);
    localparam int CW = $clog2(SCAN_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     LAST      = CW'(SCAN_LEN - 1);
    localparam logic [CW-1:0]     ISS_END   = CW'(SCAN_LEN);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCAN_LEN - 1);
    localparam logic [TW-1:0]     T_MAX     = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, UPDATE, WAIT_DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]       iss_cnt;
    logic [CW-1:0]       cnt;
    logic [TW-1:0]       tcnt;
    logic [SCAN_LEN-1:0] shadow;
    logic [ROM_LAT-1:0]  vld_pipe;
    logic [1:0]          done_sync;
    logic                done_s, iss_vld, cap, accept_wr, accept_rc, timed_out;

    assign done_s    = done_sync[1];
    assign accept_wr = (state == IDLE) && write_from_rom;
    assign accept_rc = (state == IDLE) && reconfig && !write_from_rom;
    assign iss_vld   = (state == LOAD) && (iss_cnt != ISS_END);
    // vld_pipe[ROM_LAT-1] marks the cycle a tagged ROM bit is on rom_data
    assign cap       = (state == LOAD) && vld_pipe[ROM_LAT-1];
    assign timed_out = (state == WAIT_DONE) && !done_s && (tcnt == T_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_wr)      state_nx = LOAD;
                else if (accept_rc) state_nx = SHIFT;
            end
            LOAD:      if (cap && cnt == LAST) state_nx = IDLE;
            SHIFT:     if (cnt == LAST) state_nx = UPDATE;
            UPDATE:    state_nx = WAIT_DONE;
            WAIT_DONE: if (done_s || tcnt == T_MAX) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            scandata     <= 1'b0;
            scanclkena   <= 1'b0;
            configupdate <= 1'b0;
            timeout_err  <= 1'b0;
            rom_address  <= '0;
            shadow       <= '0;
            iss_cnt      <= '0;
            cnt          <= '0;
            tcnt         <= '0;
            vld_pipe     <= '0;
            done_sync    <= '0;
        end else begin
            busy         <= (state_nx != IDLE);
            scanclkena   <= (state_nx == SHIFT);
            configupdate <= (state_nx == UPDATE);
            vld_pipe     <= ROM_LAT'({vld_pipe, iss_vld});
            done_sync    <= {done_sync[0], pll_scandone};

            if (accept_wr || accept_rc) timeout_err <= 1'b0;
            else if (timed_out)         timeout_err <= 1'b1;

            if (state == IDLE) begin
                if (accept_wr || reset_rom_address) rom_address <= '0;
            end else if (state == LOAD && rom_address != ADDR_LAST) begin
                rom_address <= rom_address + 1'b1;
            end

            if (accept_wr)    iss_cnt <= '0;
            else if (iss_vld) iss_cnt <= iss_cnt + 1'b1;

            if (accept_wr || accept_rc)           cnt <= '0;
            else if (cap || state == SHIFT)       cnt <= cnt + 1'b1;

            // Bits arrive address-ascending, so shifting in at the LSB leaves address k at [SCAN_LEN-1-k]
            if (cap) shadow <= {shadow[SCAN_LEN-2:0], rom_data};

            // Rotate SCAN_LEN times in total so the chain is intact for the next reconfig
            if (state_nx == SHIFT) begin
                scandata <= shadow[SCAN_LEN-1];
                shadow   <= {shadow[SCAN_LEN-2:0], shadow[SCAN_LEN-1]};
            end else begin
                scandata <= 1'b0;
            end

            if (state == UPDATE)                       tcnt <= TW'(1);
            else if (state == WAIT_DONE && tcnt != T_MAX) tcnt <= tcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pll_scan_responder.sv
// Bench for pll_scan_responder: directed handshake scenarios plus randomized ROM images,
// checked against a chain-level model of what the PLL should receive.
module tb_pll_scan_responder;
    localparam int SL = 8;
    localparam int AW = 4;
    localparam int RL = 2;
    localparam int TO = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic write_from_rom = 1'b0, reconfig = 1'b0, reset_rom_address = 1'b0, pll_scandone = 1'b0;
    logic rom_data;
    logic [AW-1:0] rom_address;
    logic busy, scandata, scanclkena, configupdate, timeout_err;

    int errors = 0;
    int checks = 0;

    bit rom_mem [SL];
    bit chain   [SL];
    logic r1 = 1'b0, r2 = 1'b0;

    always #5 clock = ~clock;

    pll_scan_responder #(.SCAN_LEN(SL), .ADDR_W(AW), .ROM_LAT(RL), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .write_from_rom(write_from_rom), .reconfig(reconfig),
        .reset_rom_address(reset_rom_address), .rom_address(rom_address), .rom_data(rom_data),
        .busy(busy), .scandata(scandata), .scanclkena(scanclkena), .configupdate(configupdate),
        .pll_scandone(pll_scandone), .timeout_err(timeout_err)
    );

    // Two-register ROM: data for an address appears RL clocks after it is presented
    always @(posedge clock) begin
        r1 <= (int'(rom_address) < SL) ? rom_mem[int'(rom_address)] : 1'b0;
        r2 <= r1;
    end
    assign rom_data = r2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input bit with_rc, input int stray_at,
                           output int busy_cyc, output int addr_bad, output int ena_seen);
        busy_cyc = 0; addr_bad = 0; ena_seen = 0;
        @(negedge clock); write_from_rom = 1'b1; reconfig = with_rc;
        @(negedge clock); write_from_rom = 1'b0; reconfig = 1'b0;
        for (int n = 0; n < 100 && busy; n++) begin
            busy_cyc++;
            if (int'(rom_address) != ((n < SL) ? n : SL - 1)) addr_bad++;
            if (scanclkena) ena_seen++;
            reconfig       = (n == stray_at);
            write_from_rom = (n == stray_at);
            @(negedge clock);
        end
        reconfig = 1'b0; write_from_rom = 1'b0;
        for (int i = 0; i < SL; i++) chain[i] = rom_mem[i];
    endtask

    // Cycle n counts from the first busy cycle: SHIFT n<SL, UPDATE n==SL, then WAIT_DONE
    task automatic do_reconfig(input bit give_done, input bit poke_rra, output int busy_cyc,
                               output int ena_bad, output int cu_bad, output int stream_bad,
                               output logic [SL-1:0] stream);
        busy_cyc = 0; ena_bad = 0; cu_bad = 0; stream_bad = 0; stream = '0;
        @(negedge clock); reconfig = 1'b1;
        @(negedge clock); reconfig = 1'b0;
        for (int n = 0; n < 200 && busy; n++) begin
            busy_cyc++;
            if (scanclkena !== (n < SL)) ena_bad++;
            if (configupdate !== (n == SL)) cu_bad++;
            if (n < SL) begin
                if (scandata !== chain[n]) stream_bad++;
                stream = {stream[SL-2:0], scandata};
            end
            pll_scandone      = give_done && (n >= SL + 5);
            reset_rom_address = poke_rra;
            @(negedge clock);
        end
        pll_scandone = 1'b0; reset_rom_address = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int bc, ab, es, eb, cb, sb, idle_busy;
        logic [SL-1:0] s1, s2;
        logic [7:0] pat;
        bit gd;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, scandata, scanclkena, configupdate, timeout_err}, 5'b0);
        check("reset_addr", rom_address, 0);
        reset = 1'b0;

        // Directed load: first listed bit sits at address 0
        pat = 8'b1011_0010;
        for (int k = 0; k < SL; k++) rom_mem[k] = pat[SL-1-k];
        do_load(1'b0, -1, bc, ab, es);
        check("load_busy_len", bc, SL + RL);
        check("load_addr_seq", ab, 0);
        check("load_no_ena", es, 0);

        // Shift + update + scandone 5 clocks after configupdate; reset_rom_address held while busy
        do_reconfig(1'b1, 1'b1, bc, eb, cb, sb, s1);
        check("shift_stream", s1, pat);
        check("shift_stream_model", sb, 0);
        check("shift_ena_window", eb, 0);
        check("update_pulse", cb, 0);
        check("done_busy_len", bc, SL + 1 + 5 + 2);
        check("done_no_timeout", timeout_err, 0);
        check("rra_ignored_busy", rom_address, SL - 1);
        @(negedge clock); reset_rom_address = 1'b1;
        @(negedge clock); reset_rom_address = 1'b0;
        check("rra_idle_clears", rom_address, 0);

        // Timeout: scandone never arrives
        do_reconfig(1'b0, 1'b0, bc, eb, cb, sb, s1);
        check("timeout_busy_len", bc, SL + 1 + TO);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_stream", sb, 0);

        // Collision: write+reconfig together, then stray pulses mid-LOAD
        for (int k = 0; k < SL; k++) rom_mem[k] = 1'($urandom);
        do_load(1'b1, 3, bc, ab, es);
        check("coll_busy_len", bc, SL + RL);
        check("coll_no_ena", es, 0);
        check("coll_addr_seq", ab, 0);
        check("coll_err_cleared", timeout_err, 0);
        idle_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || scanclkena) idle_busy++;
            @(negedge clock);
        end
        check("coll_single_busy", idle_busy, 0);

        // Re-shift: recirculation leaves the chain intact
        do_reconfig(1'b1, 1'b0, bc, eb, cb, sb, s1);
        check("reshift1_model", sb, 0);
        do_reconfig(1'b1, 1'b0, bc, eb, cb, sb, s2);
        check("reshift2_model", sb, 0);
        check("reshift_equal", s2, s1);

        // Randomized images and scandone behaviour
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < SL; k++) rom_mem[k] = 1'($urandom);
            gd = 1'($urandom);
            do_load(1'b0, -1, bc, ab, es);
            check("rnd_load_len", bc, SL + RL);
            check("rnd_load_addr", ab, 0);
            do_reconfig(gd, 1'b0, bc, eb, cb, sb, s1);
            check("rnd_stream", sb, 0);
            check("rnd_ctl", eb + cb, 0);
            check("rnd_busy_len", bc, gd ? SL + 8 : SL + 1 + TO);
            check("rnd_timeout_err", timeout_err, !gd);
        end

        // Reset mid-LOAD aborts and clears the shadow
        for (int k = 0; k < SL; k++) rom_mem[k] = 1'b1;
        @(negedge clock); write_from_rom = 1'b1;
        @(negedge clock); write_from_rom = 1'b0;
        repeat (3) @(negedge clock);
        check("midload_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midload_reset_out", {busy, scandata, scanclkena, configupdate, timeout_err}, 5'b0);
        check("midload_reset_addr", rom_address, 0);
        @(negedge clock); reset = 1'b0;
        for (int k = 0; k < SL; k++) chain[k] = 1'b0;
        do_reconfig(1'b1, 1'b0, bc, eb, cb, sb, s1);
        check("shadow_lost", s1, 0);
        check("post_reset_busy_len", bc, SL + 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end
endmodule
